sequence_generator: RTL and testbench
=====================================

Name: sequence_generator

Overview:
Serial pattern transmitter, the transmit end of the serial sequence-detection path. It accepts a parallel bit pattern with a length and repeat count, then drives it MSB-first, one bit per clock, onto a serial line with a valid qualifier. It produces stimulus streams, for example 101, for the team's serial sequence detectors, and emits a done pulse when the stream ends.

Parameters:
WIDTH, 8, maximum pattern length in bits.
LEN_W, 4, width of the len port; must hold values 0..WIDTH.
CNT_W, 4, width of the repeat_n port.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous reset, active-high.
start  input  1  request to begin a transfer; sampled only in IDLE.
pattern  input  WIDTH  bit pattern; the active field is pattern[len-1:0].
len  input  LEN_W  number of pattern bits per pass; 0 = empty transfer; values above WIDTH are clamped to WIDTH.
repeat_n  input  CNT_W  extra passes; total passes = repeat_n+1.
d_out  output  1  serial data bit.
d_valid  output  1  d_out carries a pattern bit this cycle.
busy  output  1  transfer in progress.
done  output  1  one-cycle pulse at end of transfer.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. All outputs are registered.
- Reset: state=IDLE; d_out=0, d_valid=0, busy=0, done=0; internal bit and pass counters are 0. Reset asserted mid-transfer aborts the transfer at the next edge. No done pulse is produced for an aborted transfer.
- States: IDLE, SHIFT, GAP (present only with the macro), DONE.
- IDLE, start=1 at edge k:
  - Capture pattern, the clamped len, and repeat_n.
  - If len=0: go to DONE; d_valid never asserts.
  - Otherwise: go to SHIFT. In the cycle after edge k, busy=1, d_valid=1 and d_out=pattern[len-1].
- SHIFT: one bit per cycle, descending index, pattern[len-1] down to pattern[0].
  - Last bit of a pass with passes remaining: the next cycle starts the next pass at pattern[len-1] with no bubble. With the macro defined, the next cycle goes to GAP instead.
  - Last bit of the final pass: go to DONE.
- Stream length: d_valid is high for exactly len*(repeat_n+1) cycles, contiguous without the macro.
- DONE: exactly one cycle with done=1, busy=0, d_valid=0; then IDLE. For a len=0 transfer, done occurs in the cycle after edge k.
- busy: high from the cycle after the start edge through the last valid bit; low in the DONE cycle and in IDLE.
- start while not in IDLE (SHIFT, GAP, DONE) is ignored; no queuing.
- Input capture: pattern, len and repeat_n are captured only at the start edge. Later input changes do not affect the transfer in progress.
- Non-valid cycles: whenever d_valid=0, d_out=0.
- Counters: the bit counter is LEN_W wide. The pass counter is CNT_W wide and counts down from repeat_n. With repeat_n at its maximum (2^CNT_W - 1), the transfer completes 2^CNT_W passes with no wrap-around error.

Optional Feature:
SEQ_GAP_EN:
- Defined: between consecutive passes, insert one GAP cycle with d_valid=0, d_out=0, busy=1. A transfer takes len*(repeat_n+1) + repeat_n cycles from the first valid bit to the last. No gap follows the final pass.
- Undefined: the GAP state is not compiled; passes are back-to-back.

Test Plan:
- Basic pattern: rst for 2 cycles; start with pattern=8'b00000101, len=3, repeat_n=0 -> d_out=1,0,1 with d_valid=1 for 3 cycles; busy=1 for those 3 cycles; done=1 in cycle 4; then IDLE.
- Repeat: pattern=3'b101 field, len=3, repeat_n=1 -> contiguous stream 101101, 6 valid cycles, single done. With SEQ_GAP_EN: 101, one invalid cycle, 101; done one cycle after the last bit.
- Boundaries: len=0, repeat_n=5 -> no d_valid, done one cycle after start. len=12, WIDTH=8, pattern=8'hA5, repeat_n=0 -> 8 bits 10100101.
- Start ignored: start held high throughout a len=4, pattern=4'b1100 transfer -> exactly one 1100 stream. A second transfer begins only after the DONE cycle, with its first bit in the cycle following the IDLE edge that samples start.
- Reset mid-operation: len=8, pattern=8'hFF, assert rst after 3 valid bits -> next cycle d_out=0, d_valid=0, busy=0; no done pulse. A fresh start after reset transmits normally.
- Counter limit: len=1, pattern bit0=1, repeat_n=4'hF -> exactly 16 valid cycles of d_out=1, then one done pulse.

Source files
------------

// File: rtl/sequence_generator.sv
// sequence_generator
//   Serial pattern transmitter. It captures a parallel pattern, a length and
//   a repeat count on start. It then shifts pattern[len-1:0] out MSB-first,
//   one bit per clock, for repeat_n+1 passes, and pulses done at the end.
//   All outputs are registered.
//
//   Optional feature macro: SEQ_GAP_EN
//     Defined   : one idle GAP cycle (d_valid=0, busy=1) between passes.
//     Undefined : passes are sent back-to-back.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   synchronous reset, active-high
//   start    in   begin a transfer (sampled only in IDLE)
//   pattern  in   [WIDTH-1:0] bit pattern, active field pattern[len-1:0]
//   len      in   [LEN_W-1:0] bits per pass, 0 = empty, clamped to WIDTH
//   repeat_n in   [CNT_W-1:0] extra passes (total = repeat_n+1)
//   d_out    out  serial data bit (0 when d_valid=0)
//   d_valid  out  d_out carries a pattern bit
//   busy     out  transfer in progress
//   done     out  one-cycle end-of-transfer pulse
module sequence_generator #(
   parameter int WIDTH = 8,
   parameter int LEN_W = 4,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] pattern,
   input  logic [LEN_W-1:0] len,
   input  logic [CNT_W-1:0] repeat_n,
   output logic             d_out,
   output logic             d_valid,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
`ifdef SEQ_GAP_EN
      ,
      GAP   = 2'd3
`endif
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pat_q, pat_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] bit_q, bit_d;
   logic [CNT_W-1:0] pass_q, pass_d;
   logic             d_out_q, d_out_d;
   logic             d_valid_q, d_valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [LEN_W-1:0] len_clamp;
   logic [LEN_W-1:0] first_idx;
   logic [LEN_W-1:0] nxt_idx;
   logic [LEN_W-1:0] top_idx;
   logic [WIDTH-1:0] sh_first;
   logic [WIDTH-1:0] sh_nxt;
   logic [WIDTH-1:0] sh_top;

   // bit_q holds the index of the bit being driven in the current cycle, so
   // the registered output for the next cycle is selected one step ahead.
   // Bit selection uses shifts so the index width need not match log2(WIDTH).
   always_comb begin
      len_clamp = (len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;
      first_idx = len_clamp - LEN_W'(1);
      nxt_idx   = bit_q - LEN_W'(1);
      top_idx   = len_q - LEN_W'(1);
      sh_first  = pattern >> first_idx;
      sh_nxt    = pat_q >> nxt_idx;
      sh_top    = pat_q >> top_idx;
   end

   always_comb begin
      state_d   = state_q;
      pat_d     = pat_q;
      len_d     = len_q;
      bit_d     = bit_q;
      pass_d    = pass_q;
      d_out_d   = 1'b0;
      d_valid_d = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               pat_d  = pattern;
               len_d  = len_clamp;
               pass_d = repeat_n;
               if (len_clamp == '0) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d   = SHIFT;
                  bit_d     = first_idx;
                  d_out_d   = sh_first[0];
                  d_valid_d = 1'b1;
                  busy_d    = 1'b1;
               end
            end
         end
         SHIFT: begin
            if (bit_q != '0) begin
               bit_d     = nxt_idx;
               d_out_d   = sh_nxt[0];
               d_valid_d = 1'b1;
               busy_d    = 1'b1;
            end else if (pass_q != '0) begin
               pass_d = pass_q - CNT_W'(1);
`ifdef SEQ_GAP_EN
               state_d = GAP;
               busy_d  = 1'b1;
`else
               bit_d     = top_idx;
               d_out_d   = sh_top[0];
               d_valid_d = 1'b1;
               busy_d    = 1'b1;
`endif
            end else begin
               state_d = DONE;
               done_d  = 1'b1;
            end
         end
`ifdef SEQ_GAP_EN
         GAP: begin
            state_d   = SHIFT;
            bit_d     = top_idx;
            d_out_d   = sh_top[0];
            d_valid_d = 1'b1;
            busy_d    = 1'b1;
         end
`endif
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         pat_q     <= '0;
         len_q     <= '0;
         bit_q     <= '0;
         pass_q    <= '0;
         d_out_q   <= 1'b0;
         d_valid_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pat_q     <= pat_d;
         len_q     <= len_d;
         bit_q     <= bit_d;
         pass_q    <= pass_d;
         d_out_q   <= d_out_d;
         d_valid_q <= d_valid_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign d_out   = d_out_q;
   assign d_valid = d_valid_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_sequence_generator.sv
// tb_sequence_generator
//   Directed bench for sequence_generator. Outputs are sampled 1 time unit
//   after each rising edge as the vector {d_out, d_valid, busy, done}.
//   Honours SEQ_GAP_EN when it is defined for the build.
module tb_sequence_generator;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] pattern;
   logic [3:0] len;
   logic [3:0] repeat_n;
   logic       d_out;
   logic       d_valid;
   logic       busy;
   logic       done;

   int unsigned total;
   int unsigned bad;

   sequence_generator #(
      .WIDTH(8),
      .LEN_W(4),
      .CNT_W(4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .pattern  (pattern),
      .len      (len),
      .repeat_n (repeat_n),
      .d_out    (d_out),
      .d_valid  (d_valid),
      .busy     (busy),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] exp);
      logic [3:0] obs;
      obs = {d_out, d_valid, busy, done};
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Called in the cycle after the start edge. Checks every pass bit by bit,
   // the optional inter-pass gap, the done cycle and the following idle cycle.
   task automatic expect_passes(input string tag, input logic [7:0] bits,
                                input int n, input int passes);
      for (int p = 0; p < passes; p++) begin
         for (int i = 0; i < n; i++) begin
            chk(tag, {bits[n-1-i], 3'b110});
            tick();
         end
`ifdef SEQ_GAP_EN
         if (p != passes - 1) begin
            chk({tag, "_gap"}, 4'b0010);
            tick();
         end
`endif
      end
      chk({tag, "_done"}, 4'b0001);
      tick();
      chk({tag, "_idle"}, 4'b0000);
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      rst      = 1'b1;
      start    = 1'b0;
      pattern  = '0;
      len      = '0;
      repeat_n = '0;
      tick();
      tick();
      chk("reset", 4'b0000);
      rst = 1'b0;
      tick();
      chk("post_reset_idle", 4'b0000);

      // Basic 101, single pass
      pattern = 8'b0000_0101; len = 4'd3; repeat_n = 4'd0; start = 1'b1;
      tick();
      start = 1'b0;
      expect_passes("basic", 8'b101, 3, 1);

      // Two passes of 101
      pattern = 8'b0000_0101; len = 4'd3; repeat_n = 4'd1; start = 1'b1;
      tick();
      start = 1'b0;
      expect_passes("repeat", 8'b101, 3, 2);

      // Empty transfer: done right after the start edge, no valid data
      pattern = 8'hFF; len = 4'd0; repeat_n = 4'd5; start = 1'b1;
      tick();
      start = 1'b0;
      chk("len0_done", 4'b0001);
      tick();
      chk("len0_idle", 4'b0000);
      tick();
      chk("len0_idle2", 4'b0000);

      // len above WIDTH clamps to 8 bits
      pattern = 8'hA5; len = 4'd12; repeat_n = 4'd0; start = 1'b1;
      tick();
      start = 1'b0;
      expect_passes("clamp", 8'hA5, 8, 1);

      // start held high: one stream, then a second one after DONE
      pattern = 8'b0000_1100; len = 4'd4; repeat_n = 4'd0; start = 1'b1;
      tick();
      expect_passes("hold1", 8'b1100, 4, 1);
      tick();
      start   = 1'b0;
      pattern = 8'h00;  // changes after the start edge must not matter
      len     = 4'd1;
      expect_passes("hold2", 8'b1100, 4, 1);

      // Reset after three valid bits aborts with no done
      pattern = 8'hFF; len = 4'd8; repeat_n = 4'd0; start = 1'b1;
      tick();
      start = 1'b0;
      chk("abort_b0", 4'b1110);
      tick();
      chk("abort_b1", 4'b1110);
      tick();
      chk("abort_b2", 4'b1110);
      rst = 1'b1;
      tick();
      chk("abort_rst", 4'b0000);
      rst = 1'b0;
      tick();
      chk("abort_nodone", 4'b0000);
      tick();
      chk("abort_nodone2", 4'b0000);

      pattern = 8'b0000_0101; len = 4'd3; repeat_n = 4'd0; start = 1'b1;
      tick();
      start = 1'b0;
      expect_passes("after_abort", 8'b101, 3, 1);

      // Maximum repeat count: 16 passes of a single 1
      pattern = 8'b0000_0001; len = 4'd1; repeat_n = 4'hF; start = 1'b1;
      tick();
      start = 1'b0;
      expect_passes("cnt_limit", 8'b1, 1, 16);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
